fetch_stage_ctrl: RTL
=====================

Name: fetch_stage_ctrl

Overview:
- Instruction-fetch front end of the RV32I pipeline. It is the responder to the hazard unit's StallF/StallD/FlushD/PCSrcE commands.
- Owns the PC register, runs a req/ack handshake to a multi-cycle instruction memory, and drives the IF/ID pipeline register.
- Holds one fetched word in a skid buffer while decode is stalled.
- Reports FetchBusyF back to the hazard unit while no instruction is available.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, word driven on InstrD when the IF/ID register holds a bubble (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- StallF  in  1  hazard unit: hold PC, issue no new fetch.
- StallD  in  1  hazard unit: hold the IF/ID register.
- FlushD  in  1  hazard unit: load a bubble into IF/ID.
- PCSrcE  in  1  taken branch/jump resolved in execute.
- PCTargetE  in  32  redirect target.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  32  fetch address, registered, stable while imem_req=1.
- imem_ack  in  1  one-cycle strobe: imem_rdata valid.
- imem_rdata  in  32  fetched instruction word.
- InstrD  out  32  IF/ID instruction.
- PCD  out  32  IF/ID PC.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.
- FetchBusyF  out  1  combinational: no instruction is available for decode this cycle.

Behaviour:
- Reset (async, rst=1):
  - PC=RESET_PC, state=FETCH.
  - imem_req=0, imem_addr=RESET_PC.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, skid buffer empty.
  - imem_req rises 1 cycle after rst deasserts.
- Memory protocol:
  - imem_req stays high with imem_addr constant until the cycle imem_ack=1. imem_ack is ignored when imem_req=0.
  - Next request: at the earliest, imem_req is re-driven high the cycle after ack with the new address. Back-to-back throughput is one fetch per (memory latency + 1) cycles.
- States:
  - FETCH, request outstanding. On ack:
    - if StallD=0, load IF/ID (InstrD=rdata, PCD=PC, PCPlus4D=PC+4, ValidD=1). PC<=PC+4. Stay in FETCH and request PC+4.
    - if StallD=1, write rdata/PC to the skid buffer and go to HOLD. PC is not advanced.
  - HOLD, buffer full, imem_req=0. On the first cycle with StallD=0:
    - load IF/ID from the buffer and clear the buffer.
    - PC<=PC+4, go to FETCH.
  - DROP, redirect arrived while a request was outstanding. Keep imem_req/imem_addr until ack, then discard rdata. Go to FETCH at the saved target.
- Bubbles: if StallD=0 and no ack or buffer data this cycle, IF/ID loads a bubble (ValidD=0, InstrD=NOP_INSTR). FetchBusyF=1 in that case.
- Priorities, high to low: rst > PCSrcE > FlushD > StallD > normal load.
- Redirect (PCSrcE=1):
  - PC/target <= {PCTargetE[31:2],2'b00}. The skid buffer is cleared.
  - From FETCH without ack: go to DROP. From FETCH with ack in the same cycle: rdata is discarded and a new request is issued next cycle. From HOLD: go to FETCH.
  - A second PCSrcE while in DROP overwrites the saved target.
- FlushD=1: IF/ID <= bubble regardless of StallD. A fetched word arriving that cycle is kept, in the buffer or IF/ID, only if PCSrcE=0.
- StallF=1 with StallD=0 does not occur. If it does, it is treated as StallD=1.
- PC arithmetic is modulo 2^32: PC 32'hFFFF_FFFC increments to 32'h0000_0000.

Optional Feature:
- Macro FETCH_MISALIGN_CHK_EN.
- Defined:
  - adds output port MisalignF (1 bit, reset 0).
  - MisalignF pulses high for exactly one cycle, the cycle after a PCSrcE with PCTargetE[1:0]!=0.
  - The fetch still proceeds at the aligned address.
- Undefined: the port is absent and PCTargetE[1:0] is silently dropped.

Test Plan:
- Reset, then memory with 2-cycle ack latency, no stalls -> imem_addr sequence 0,4,8. PCD=0/4/8 with ValidD=1, separated by bubbles (ValidD=0, InstrD=32'h13).
- StallD=1 for 3 cycles while ack for addr 0x10 arrives -> state HOLD, imem_req=0, IF/ID unchanged. After release: InstrD=that word, PCD=0x10, next imem_addr=0x14.
- PCSrcE=1 with PCTargetE=0x200 while the fetch of 0x20 is outstanding -> imem_addr stays 0x20 until ack. That word never reaches IF/ID; the next imem_addr is 0x200.
- PCSrcE and imem_ack in the same cycle -> ack data discarded, ValidD=0 next cycle, imem_req=1 with addr=PCTargetE on the cycle after.
- rst asserted mid-request (state DROP) -> imem_req=0 and ValidD=0 immediately (async). Fetch restarts at RESET_PC.
- PC=32'hFFFF_FFFC fetched -> PCPlus4D=0, next imem_addr=0. With FETCH_MISALIGN_CHK_EN: a redirect to 0x102 gives MisalignF high for 1 cycle and imem_addr=0x100.

Source files
------------

// File: rtl/fetch_stage_ctrl.sv
// fetch_stage_ctrl: RV32I fetch front end with PC, imem req/ack handshake, skid buffer and IF/ID register.
// Define FETCH_MISALIGN_CHK_EN to add the MisalignF redirect-alignment flag.
module fetch_stage_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        StallD,
   input  logic        FlushD,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PCD,
   output logic [31:0] PCPlus4D,
   output logic        ValidD,
`ifdef FETCH_MISALIGN_CHK_EN
   output logic        MisalignF,
`endif
   output logic        FetchBusyF
);
   typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
   state_t state;
   logic [31:0] pc, skidInstr, pcPlus4, target;
   logic stallAny, ackF, load, bubble;
   // The skid buffer shares pc: PC does not advance while a word is held.
   assign pcPlus4  = pc + 32'd4;
   assign target   = PCTargetE & ~32'h3;
   assign stallAny = StallD | StallF;
   assign ackF     = state == FETCH && imem_req && imem_ack;
   assign FetchBusyF = !(ackF || state == HOLD);
   assign load     = !PCSrcE && !FlushD && !stallAny && !FetchBusyF;
   assign bubble   = PCSrcE || FlushD || (!stallAny && FetchBusyF);
`ifdef FETCH_MISALIGN_CHK_EN
   always_ff @(posedge clk or posedge rst)
      if (rst) MisalignF <= 1'b0;
      else     MisalignF <= PCSrcE && PCTargetE[1:0] != 2'b00;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FETCH;
         pc        <= RESET_PC;
         skidInstr <= NOP_INSTR;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         InstrD    <= NOP_INSTR;
         PCD       <= 32'd0;
         PCPlus4D  <= 32'd0;
         ValidD    <= 1'b0;
      end else begin
         if (bubble) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
         end else if (load) begin
            InstrD   <= state == HOLD ? skidInstr : imem_rdata;
            PCD      <= pc;
            PCPlus4D <= pcPlus4;
            ValidD   <= 1'b1;
         end
         case (state)
            FETCH: begin
               if (PCSrcE) begin
                  pc <= target;
                  if (imem_req && !imem_ack) state <= DROP;
                  else imem_req <= 1'b0;
               end else if (ackF) begin
                  imem_req <= 1'b0;
                  if (load) pc <= pcPlus4;
                  else begin
                     skidInstr <= imem_rdata;
                     state     <= HOLD;
                  end
               end else if (!imem_req && !StallF) begin
                  imem_req  <= 1'b1;
                  imem_addr <= pc;
               end
            end
            HOLD: begin
               if (PCSrcE) begin
                  pc    <= target;
                  state <= FETCH;
               end else if (load) begin
                  pc    <= pcPlus4;
                  state <= FETCH;
               end
            end
            DROP: begin
               if (PCSrcE) pc <= target;
               if (imem_ack) begin
                  imem_req <= 1'b0;
                  state    <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end
endmodule
